// File: rtl/ram_bus_master_if.sv
// rtl/ram_bus_master_if.sv - control-side handshake and RAM strobe bundle for ram_bus_master
// Purpose: groups the req/done handshake and the RAM strobes/address.
//   The bidirectional RAM data bus is a plain inout on the master, not part of this bundle.
// Signals:
//   req, we, addr[7:0], wdata[7:0] : transfer request from the control unit
//   busy, done, rdata[7:0], vf_err : transfer status/result back to the control unit
//   ope, ctl, ena (active low), adr[7:0] : RAM strobes and address
// Modports: master (ram_bus_master view), slave (control unit / RAM view)
interface ram_bus_master_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       vf_err;
  logic       ope;
  logic       ctl;
  logic       ena;
  logic [7:0] adr;

  modport master (
    input  req, we, addr, wdata,
    output busy, done, rdata, vf_err, ope, ctl, ena, adr
  );

  modport slave (
    output req, we, addr, wdata,
    input  busy, done, rdata, vf_err, ope, ctl, ena, adr
  );
endinterface

// File: rtl/ram_bus_master.sv
// rtl/ram_bus_master.sv - clocked initiator for the 8-bit asynchronous subleq RAM
// Purpose: turns a req/done handshake into setup/strobe/hold/turnaround
//   sequences on ope/ctl/ena/adr/dat, never letting master and RAM drive dat together.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : ram_bus_master_if.master (req/we/addr/wdata in, busy/done/rdata/vf_err
//                and RAM strobes ope/ctl/ena/adr out)
//   dat[7:0]   : RAM data bus, driven only while a write is in progress
// Parameters: WAIT_RD (0..15) extra output-enable cycles, WR_PULSE (1..15) ctl-low cycles.
// Option: define RAM_BUS_MASTER_VERIFY_EN to read back every write and flag mismatches on vf_err.
module ram_bus_master #(
  parameter int WAIT_RD  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_bus_master_if.master      bus,
  inout  wire  [7:0]            dat
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD_OE,
    S_WR_SETUP,
    S_WR_STROBE,
    S_WR_HOLD,
    S_VF_TURN,
    S_VF_OE,
    S_TURN
  } state_t;

  // Both waits share one down-counter; it is loaded one state early so the
  // state it times lasts exactly load+1 cycles.
  localparam logic [3:0] RD_CNT = 4'(WAIT_RD);
  localparam logic [3:0] WR_CNT = 4'(WR_PULSE - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] wdata_q;
  logic [7:0] adr_q;
  logic       ope_q;
  logic       ctl_q;
  logic       ena_q;
  logic       dat_oe_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] rdata_q;
`ifdef RAM_BUS_MASTER_VERIFY_EN
  logic       vf_err_q;
`endif

  // All outputs are registered: each state's strobe levels are loaded on the
  // edge that enters that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wdata_q  <= '0;
      adr_q    <= '0;
      ope_q    <= 1'b1;
      ctl_q    <= 1'b1;
      ena_q    <= 1'b1;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
`ifdef RAM_BUS_MASTER_VERIFY_EN
      vf_err_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            wdata_q <= bus.wdata;
            adr_q   <= bus.addr;
            ena_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef RAM_BUS_MASTER_VERIFY_EN
            vf_err_q <= 1'b0;
`endif
            if (bus.we) begin
              dat_oe_q <= 1'b1;
              state_q  <= S_WR_SETUP;
            end else begin
              state_q  <= S_RD_SETUP;
            end
          end
        end
        S_RD_SETUP: begin
          ope_q   <= 1'b0;
          cnt_q   <= RD_CNT;
          state_q <= S_RD_OE;
        end
        S_RD_OE: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= dat;
            ope_q   <= 1'b1;
            ena_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_TURN;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WR_SETUP: begin
          ctl_q   <= 1'b0;
          cnt_q   <= WR_CNT;
          state_q <= S_WR_STROBE;
        end
        S_WR_STROBE: begin
          if (cnt_q == 4'd0) begin
            ctl_q   <= 1'b1;
            state_q <= S_WR_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WR_HOLD: begin
          dat_oe_q <= 1'b0;
`ifdef RAM_BUS_MASTER_VERIFY_EN
          // Keep the chip selected; the read-back uses the same address.
          state_q  <= S_VF_TURN;
`else
          ena_q    <= 1'b1;
          done_q   <= 1'b1;
          state_q  <= S_TURN;
`endif
        end
`ifdef RAM_BUS_MASTER_VERIFY_EN
        S_VF_TURN: begin
          ope_q   <= 1'b0;
          cnt_q   <= RD_CNT;
          state_q <= S_VF_OE;
        end
        S_VF_OE: begin
          if (cnt_q == 4'd0) begin
            rdata_q  <= dat;
            vf_err_q <= (dat != wdata_q);
            ope_q    <= 1'b1;
            ena_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_TURN;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        S_TURN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.ope   = ope_q;
  assign bus.ctl   = ctl_q;
  assign bus.ena   = ena_q;
  assign bus.adr   = adr_q;
`ifdef RAM_BUS_MASTER_VERIFY_EN
  assign bus.vf_err = vf_err_q;
`else
  assign bus.vf_err = 1'b0;
`endif

  // dat_oe_q drops on the edge into VF_TURN/TURN, one state before any ope=0.
  assign dat = dat_oe_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_ram_bus_master.sv
// tb/tb_ram_bus_master.sv - self-checking bench for ram_bus_master (default and WAIT_RD=3/WR_PULSE=2)
// Purpose: drives two masters against behavioural async RAMs and checks strobes,
//   latency, data and reset behaviour. Honours RAM_BUS_MASTER_VERIFY_EN when defined.
module tb_ram_bus_master;

  localparam int W0 = 1, P0 = 1, W1 = 3, P1 = 2;
`ifdef RAM_BUS_MASTER_VERIFY_EN
  localparam bit VF = 1'b1;
`else
  localparam bit VF = 1'b0;
`endif

  logic clk;
  logic rst;
  logic ram_clr;
  logic force_bad;
  wire [7:0] dat0;
  wire [7:0] dat1;

  ram_bus_master_if bus0 ();
  ram_bus_master_if bus1 ();

  ram_bus_master #(.WAIT_RD(W0), .WR_PULSE(P0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master), .dat(dat0)
  );
  ram_bus_master #(.WAIT_RD(W1), .WR_PULSE(P1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master), .dat(dat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural async RAMs: drive when selected and output-enabled in read mode,
  // capture on the falling edge of ctl while selected.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  function automatic logic [7:0] init_val(input int a);
    return (a == 1) ? 8'h06 : 8'h00;
  endfunction

  assign dat0 = (!bus0.ena && !bus0.ope && bus0.ctl) ?
                ((force_bad && bus0.adr == 8'h20) ? 8'h3D : mem0[bus0.adr]) : 8'hzz;
  assign dat1 = (!bus1.ena && !bus1.ope && bus1.ctl) ? mem1[bus1.adr] : 8'hzz;

  always @(negedge bus0.ctl or posedge ram_clr) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) mem0[i] = init_val(i);
    end else if (!bus0.ena) begin
      mem0[bus0.adr] = dat0;
    end
  end

  always @(negedge bus1.ctl or posedge ram_clr) begin
    if (ram_clr) begin
      for (int j = 0; j < 256; j++) mem1[j] = init_val(j);
    end else if (!bus1.ena) begin
      mem1[bus1.adr] = dat1;
    end
  end

  int vecs = 0;
  int miss = 0;

  typedef struct {
    logic       busy, done, vf, ope, ctl, ena;
    logic [7:0] rdata, adr, dat;
  } snap_t;

  typedef struct {
    int         lat;
    int         ope_lo;
    int         ctl_lo;
    bit         chk_rd;
    logic [7:0] rdata;
    logic       vf;
  } sb_t;

  sb_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (k == 0) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = d;
    end
  endtask

  task automatic snap(input int k, output snap_t s);
    if (k == 0) begin
      s.busy = bus0.busy; s.done = bus0.done; s.vf = bus0.vf_err; s.ope = bus0.ope;
      s.ctl = bus0.ctl; s.ena = bus0.ena; s.rdata = bus0.rdata; s.adr = bus0.adr; s.dat = dat0;
    end else begin
      s.busy = bus1.busy; s.done = bus1.done; s.vf = bus1.vf_err; s.ope = bus1.ope;
      s.ctl = bus1.ctl; s.ena = bus1.ena; s.rdata = bus1.rdata; s.adr = bus1.adr; s.dat = dat1;
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    snap_t s;
    snap(k, s);
    chk({tag, "_ope"},   32'(s.ope),   32'd1);
    chk({tag, "_ctl"},   32'(s.ctl),   32'd1);
    chk({tag, "_ena"},   32'(s.ena),   32'd1);
    chk({tag, "_busy"},  32'(s.busy),  32'd0);
    chk({tag, "_done"},  32'(s.done),  32'd0);
    chk({tag, "_rdata"}, 32'(s.rdata), 32'd0);
    chk({tag, "_adr"},   32'(s.adr),   32'd0);
    chk({tag, "_vf"},    32'(s.vf),    32'd0);
  endtask

  // One transfer: push expectations, accept, watch strobes every cycle, pop and
  // compare at done. pulse_at>0 raises req for one cycle at that cycle number.
  task automatic xfer(input int k, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] exp_rd,
                      input logic exp_vf, input int pulse_at);
    snap_t s;
    sb_t   e;
    int    n, ope_lo, ctl_lo, wr, pw;
    wr = (k == 0) ? W0 : W1;
    pw = (k == 0) ? P0 : P1;
    e.lat    = w ? (VF ? pw + wr + 5 : pw + 3) : wr + 3;
    e.ope_lo = (!w || VF) ? wr + 1 : 0;
    e.ctl_lo = w ? pw : 0;
    e.chk_rd = !w || VF;
    e.rdata  = exp_rd;
    e.vf     = exp_vf;
    sbq.push_back(e);

    @(negedge clk);
    drive(k, 1'b1, w, a, d);
    @(posedge clk); #1;
    drive(k, 1'b0, ~w, ~a, ~d);
    n = 1; ope_lo = 0; ctl_lo = 0;
    snap(k, s);
    chk("accept_busy", 32'(s.busy), 32'd1);
    chk("accept_vf_clear", 32'(s.vf), 32'd0);
    chk("accept_adr", 32'(s.adr), 32'(a));
    while (1) begin
      if (!s.ope) begin
        ope_lo++;
        chk("ope_low_ctl_high", 32'(s.ctl), 32'd1);
      end
      if (!s.ctl) begin
        ctl_lo++;
        chk("strobe_dat", 32'(s.dat), 32'(d));
        chk("strobe_ena", 32'(s.ena), 32'd0);
      end
      if (s.done || n >= 40) break;
      if (pulse_at > 0 && n == pulse_at) drive(k, 1'b1, 1'b1, 8'h55, 8'hEE);
      else if (pulse_at > 0 && n == pulse_at + 1) drive(k, 1'b0, 1'b0, 8'h00, 8'h00);
      @(posedge clk); #1;
      n++;
      snap(k, s);
    end
    e = sbq.pop_front();
    chk("done_seen", 32'(s.done), 32'd1);
    chk("latency", 32'(n), 32'(e.lat));
    chk("ope_low_cycles", 32'(ope_lo), 32'(e.ope_lo));
    chk("ctl_low_cycles", 32'(ctl_lo), 32'(e.ctl_lo));
    chk("done_busy", 32'(s.busy), 32'd1);
    chk("done_ena", 32'(s.ena), 32'd1);
    chk("vf_err", 32'(s.vf), 32'(e.vf));
    if (e.chk_rd) chk("rdata", 32'(s.rdata), 32'(e.rdata));
    drive(k, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    snap(k, s);
    chk("post_busy", 32'(s.busy), 32'd0);
    chk("post_done", 32'(s.done), 32'd0);
  endtask

  initial begin
    snap_t s;
    int    n;
    rst = 1'b1; ram_clr = 1'b0; force_bad = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    #1 ram_clr = 1'b1;
    #1 ram_clr = 1'b0;

    // Reset for two cycles, then idle values on both masters.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle(0, "reset0");
    chk_idle(1, "reset1");

    // Default read, write then read-back.
    xfer(0, 1'b0, 8'h01, 8'h00, 8'h06, 1'b0, 0);
    xfer(0, 1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0, 0);
    chk("mem_10", 32'(mem0[8'h10]), 32'hA5);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 0);

    // WAIT_RD=3, WR_PULSE=2 instance.
    xfer(1, 1'b0, 8'h01, 8'h00, 8'h06, 1'b0, 0);
    xfer(1, 1'b1, 8'h44, 8'h5B, 8'h5B, 1'b0, 0);
    xfer(1, 1'b0, 8'h44, 8'h00, 8'h5B, 1'b0, 0);

    // req pulsed while busy must be dropped.
    xfer(0, 1'b0, 8'h01, 8'h00, 8'h06, 1'b0, 2);
    @(posedge clk); #1;
    snap(0, s);
    chk("ignored_req_busy", 32'(s.busy), 32'd0);
    chk("ignored_req_mem", 32'(mem0[8'h55]), 32'h00);

    // req held high: back-to-back reads with a 1-cycle IDLE gap.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    n = 0;
    do begin @(posedge clk); #1; n++; snap(0, s); end while (!s.done && n < 40);
    chk("b2b_first_done", 32'(s.done), 32'd1);
    @(posedge clk); #1; snap(0, s);
    chk("b2b_gap_busy", 32'(s.busy), 32'd0);
    @(posedge clk); #1; snap(0, s);
    chk("b2b_second_accept", 32'(s.busy), 32'd1);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    n = 0;
    do begin @(posedge clk); #1; n++; snap(0, s); end while (!s.done && n < 40);
    chk("b2b_second_done", 32'(s.done), 32'd1);
    chk("b2b_rdata", 32'(s.rdata), 32'h06);
    @(posedge clk); #1;

    // Reset while ctl is low: everything back to idle at the next edge.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h30, 8'h77);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1; snap(0, s);
    chk("strobe_ctl_low", 32'(s.ctl), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle(0, "rst_strobe");

    // Reset during setup: no falling ctl edge, so the location is untouched.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h31, 8'h88);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle(0, "rst_setup");
    chk("rst_setup_mem", 32'(mem0[8'h31]), 32'h00);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 0);

`ifdef RAM_BUS_MASTER_VERIFY_EN
    // Read-back corrupted by the RAM model: flag raised, bad value returned.
    force_bad = 1'b1;
    xfer(0, 1'b1, 8'h20, 8'h3C, 8'h3D, 1'b1, 0);
    force_bad = 1'b0;
    @(posedge clk); #1; snap(0, s);
    chk("vf_err_holds", 32'(s.vf), 32'd1);
    xfer(0, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Clocked initiator for the 8-bit-address, 8-bit-data asynchronous RAM interface used in the subleq machine.
- Control-unit side: simple req/done handshake.
- RAM side: generates the active-low strobes ope (output enable), ctl (1 = read, 0 = write) and ena (chip enable), plus the shared bidirectional data bus.
- Sequences setup, strobe, hold and bus turnaround so the master and the RAM never drive dat at the same time.
- Sits between the subleq control FSM and the RAM.

Parameters:
- WAIT_RD, 1: extra cycles ope stays low before read data is sampled. Range 0..15.
- WR_PULSE, 1: number of cycles ctl is held low during a write. Range 1..15.

Ports:
- clk  in  1  system clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  start a transfer; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; latched at accept.
- addr  in  8  transfer address; latched at accept.
- wdata  in  8  write data; latched at accept.
- busy  out  1  high from the accept edge through the TURN cycle.
- done  out  1  one-cycle pulse in the TURN cycle.
- rdata  out  8  read data; valid from done until the next read completes.
- vf_err  out  1  write-verify mismatch flag (see Optional Feature).
- ope  out  1  RAM output enable, active low.
- ctl  out  1  RAM read/write select; writes on its falling edge.
- ena  out  1  RAM chip enable, active low.
- adr  out  8  RAM address.
- dat  inout  8  RAM data bus; master drives it only in write states, otherwise high-Z.

Behaviour:
- Reset / idle values: ope=1, ctl=1, ena=1, adr=0, dat=Z, busy=0, done=0, rdata=0, vf_err=0, state=IDLE.
- rst in any state returns all outputs to these values at the next edge. A reset during WR_STROBE raises ctl; the RAM ignores rising edges, so no spurious write occurs.
- Outputs are registered. Use one 4-bit down-counter for WAIT_RD and WR_PULSE.
- IDLE: when req=1, latch we/addr/wdata, set busy=1, go to RD_SETUP or WR_SETUP. req=0 leaves the block in IDLE.
- RD_SETUP (1 cycle): adr=addr, ena=0, ctl=1, ope=1, dat=Z.
- RD_OE (WAIT_RD+1 cycles): ope=0. On the edge ending the last RD_OE cycle, rdata<=dat; go to TURN.
- WR_SETUP (1 cycle): adr=addr, dat driven with wdata, ena=0, ctl=1, ope=1.
- WR_STROBE (WR_PULSE cycles): ctl=0; the RAM captures on the falling edge.
- WR_HOLD (1 cycle): ctl=1, dat and adr still driven, ena=0. Then go to TURN, or to VF_TURN when the feature is enabled.
- TURN (1 cycle): ope=1, ctl=1, ena=1, dat=Z, done=1, busy=1. Next state is IDLE.
- Latency from accept edge to done cycle:
  - read: WAIT_RD+3 cycles (4 at default);
  - write: WR_PULSE+3 cycles (4 at default).
- Invariant: dat is never driven while ope=0.
- Invariant: ope=0 is never asserted while ctl=0.
- req while busy=1 is ignored; there is no queue.
- A req held high is accepted on the first IDLE cycle after TURN, giving back-to-back transfers with a 1-cycle IDLE gap.
- addr/we/wdata changing after accept has no effect.
- adr holds its last value in IDLE.

Optional Feature:
- Macro: RAM_BUS_MASTER_VERIFY_EN.
- With the macro defined, every write is followed by a read-back of the same address:
  - WR_HOLD goes to VF_TURN (1 cycle): dat=Z, ctl=1, ope=1, ena=0.
  - Then VF_OE (WAIT_RD+1 cycles): ope=0; the last edge samples dat into rdata and sets vf_err = (dat != wdata).
  - Then TURN.
  - Write latency becomes WR_PULSE+WAIT_RD+5 cycles.
  - vf_err holds until the next accept, which clears it.
- Without the macro: no verify states, vf_err is tied to 0, and write latency is WR_PULSE+3 cycles.

Test Plan:
- Reset then idle: rst high 2 cycles -> ope=ctl=ena=1, dat=Z, busy=0, rdata=0.
- Default read: RAM mem[0x01]=0x06; req=1, we=0, addr=0x01 -> ope low for 2 cycles, done in cycle 4 after accept, rdata=0x06, dat never driven by the master.
- Default write then read: write addr=0x10, wdata=0xA5 -> ctl low exactly 1 cycle with dat=0xA5 and ena=0; a subsequent read of 0x10 returns 0xA5.
- Parameters WAIT_RD=3, WR_PULSE=2: read -> ope low 4 cycles, done at cycle 6; write -> ctl low 2 cycles, done at cycle 5.
- Busy/reset: req pulsed during busy -> ignored. rst asserted in WR_STROBE -> next edge all idle values, and the RAM location is unchanged when ena/ctl never completed a falling edge after setup.
- With RAM_BUS_MASTER_VERIFY_EN: write 0x3C to 0x20 with the RAM model forcing a readback of 0x3D -> vf_err=1 at done, rdata=0x3D; the next accept clears vf_err.
